// File: rtl/mario_sprite_fetch_if.sv
// mario_sprite_fetch_if: bundles the pixel-position inputs, animation controls, the sprite ROM
// bus and the pixel outputs of the Mario sprite fetcher.
//   master : the fetcher (drives read_address/frame_sel/pixel_on/pixel_color)
//   slave  : the surrounding video pipeline and sprite ROM (drives everything else)
// Signals:
//   frame_clk            vsync-rate level, synchronous to the system clock
//   DrawX, DrawY         current VGA pixel coordinate
//   MarioX, MarioY       sprite top-left coordinate
//   walking, facing_left animation / orientation controls
//   read_address         sprite ROM address, row-major
//   frame_sel            walk-frame ROM select (0 stand, 1..3 walk)
//   rom_color            combinational ROM data for read_address/frame_sel
//   pixel_on             opaque sprite pixel present
//   pixel_color          sprite colour, 0 when pixel_on is low
interface mario_sprite_fetch_if;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  MarioX;
    logic [9:0]  MarioY;
    logic        walking;
    logic        facing_left;
    logic [8:0]  read_address;
    logic [1:0]  frame_sel;
    logic [11:0] rom_color;
    logic        pixel_on;
    logic [11:0] pixel_color;

    modport master (
        input  frame_clk, DrawX, DrawY, MarioX, MarioY, walking, facing_left, rom_color,
        output read_address, frame_sel, pixel_on, pixel_color
    );

    modport slave (
        output frame_clk, DrawX, DrawY, MarioX, MarioY, walking, facing_left, rom_color,
        input  read_address, frame_sel, pixel_on, pixel_color
    );
endinterface

// File: rtl/mario_sprite_fetch.sv
// mario_sprite_fetch: turns the current VGA coordinate into a sprite ROM address, tracks the
// walk animation frame, and produces the keyed sprite pixel two cycles later.
// Ports:
//   Clk    system clock, all state on the rising edge
//   Reset  asynchronous active-high reset
//   bus    mario_sprite_fetch_if.master (see the interface header for the signal list)
// Parameters: SPR_W, SPR_H (sprite size, SPR_W*SPR_H <= 512), ANIM_DIV (frame_clk edges per
//   walk-frame advance, 1..15), KEY_COLOR (transparent palette colour).
// Build option: define MARIO_MIRROR_EN to mirror the sprite horizontally when facing_left is
//   high; otherwise facing_left is ignored.
module mario_sprite_fetch #(
    parameter int unsigned SPR_W     = 21,
    parameter int unsigned SPR_H     = 21,
    parameter int unsigned ANIM_DIV  = 4,
    parameter logic [11:0] KEY_COLOR = 12'h808
) (
    input logic                  Clk,
    input logic                  Reset,
    mario_sprite_fetch_if.master bus
);

    if (SPR_W * SPR_H > 512) begin : gen_size_check
        $error("SPR_W*SPR_H must not exceed 512");
    end
    if (ANIM_DIV < 1 || ANIM_DIV > 15) begin : gen_div_check
        $error("ANIM_DIV must be in 1..15");
    end

    typedef enum logic [1:0] {
        StStand = 2'd0,
        StWalk1 = 2'd1,
        StWalk2 = 2'd2,
        StWalk3 = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic [3:0]  div_inc;
    logic        fclk_q;
    logic        fclk_rise;

    logic        in_box;
    logic [8:0]  col_raw;
    logic [8:0]  row_raw;
    logic [8:0]  col_eff;
    logic [8:0]  addr;

    logic        in_box_q;
    logic [8:0]  read_address_q;
    logic [1:0]  frame_sel_q;
    logic        pixel_on_d;
    logic        pixel_on_q;
    logic [11:0] pixel_color_q;

    // Compare at 11 bits so a sprite near x/y = 1023 does not wrap into column 0.
    logic [10:0] draw_x_w, draw_y_w, mario_x_w, mario_y_w;
    assign draw_x_w  = {1'b0, bus.DrawX};
    assign draw_y_w  = {1'b0, bus.DrawY};
    assign mario_x_w = {1'b0, bus.MarioX};
    assign mario_y_w = {1'b0, bus.MarioY};

    assign in_box = (draw_x_w >= mario_x_w) && (draw_x_w < mario_x_w + 11'(SPR_W)) &&
                    (draw_y_w >= mario_y_w) && (draw_y_w < mario_y_w + 11'(SPR_H));

    // Only meaningful when in_box; the offsets then fit in 9 bits.
    assign col_raw = 9'(bus.DrawX - bus.MarioX);
    assign row_raw = 9'(bus.DrawY - bus.MarioY);

`ifdef MARIO_MIRROR_EN
    assign col_eff = bus.facing_left ? (9'(SPR_W - 1) - col_raw) : col_raw;
`else
    assign col_eff = col_raw;
    logic unused_facing_left;
    assign unused_facing_left = bus.facing_left;
`endif

    assign addr = row_raw * 9'(SPR_W) + col_eff;

    // ---------------------------------------------------------------- animation FSM
    assign fclk_rise = bus.frame_clk & ~fclk_q;
    assign div_inc   = div_q + 4'd1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        if (!bus.walking) begin
            // Stopping wins over any advance happening on the same edge.
            state_d = StStand;
            div_d   = '0;
        end else if (fclk_rise) begin
            if (state_q == StStand) begin
                state_d = StWalk1;
                div_d   = '0;
            end else if (div_inc == 4'(ANIM_DIV)) begin
                div_d = '0;
                unique case (state_q)
                    StWalk1: state_d = StWalk2;
                    StWalk2: state_d = StWalk3;
                    StWalk3: state_d = StWalk1;
                    default: state_d = StStand;
                endcase
            end else begin
                div_d = div_inc;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StStand;
            div_q   <= '0;
            fclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            fclk_q  <= bus.frame_clk;
        end
    end

    // ---------------------------------------------------------------- pixel pipeline
    assign pixel_on_d = in_box_q && (bus.rom_color != KEY_COLOR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            in_box_q       <= 1'b0;
            read_address_q <= '0;
            frame_sel_q    <= '0;
            pixel_on_q     <= 1'b0;
            pixel_color_q  <= '0;
        end else begin
            in_box_q       <= in_box;
            read_address_q <= in_box ? addr : 9'd0;
            // Frame select only moves at the top-left pixel so a frame never mixes walk frames.
            if (bus.DrawX == 10'd0 && bus.DrawY == 10'd0) begin
                frame_sel_q <= state_q;
            end
            pixel_on_q     <= pixel_on_d;
            pixel_color_q  <= pixel_on_d ? bus.rom_color : 12'h000;
        end
    end

    assign bus.read_address = read_address_q;
    assign bus.frame_sel    = frame_sel_q;
    assign bus.pixel_on     = pixel_on_q;
    assign bus.pixel_color  = pixel_color_q;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Testbench for mario_sprite_fetch: directed vector table, randomized pipeline stream checked
// against a coordinate-level reference model, and hand sequences for animation and reset.
module tb_mario_sprite_fetch;

    localparam int unsigned SPR_W     = 21;
    localparam int unsigned SPR_H     = 21;
    localparam int unsigned ANIM_DIV  = 4;
    localparam logic [11:0] KEY_COLOR = 12'h808;

`ifdef MARIO_MIRROR_EN
    localparam logic [8:0] EXP_MIR = 9'd59;
`else
    localparam logic [8:0] EXP_MIR = 9'd45;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mario_sprite_fetch_if bus ();

    mario_sprite_fetch #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .ANIM_DIV (ANIM_DIV),
        .KEY_COLOR(KEY_COLOR)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // Sprite ROM stand-in: either a fixed forced colour or an address-derived pattern.
    logic        rom_force_en = 1'b1;
    logic [11:0] rom_force_val = 12'hF30;

    function automatic logic [11:0] rom_fn(input logic [8:0] a, input logic [1:0] fs);
        if (a[2:0] == 3'd5) return KEY_COLOR;
        return {fs, 1'b1, a};
    endfunction

    assign bus.rom_color = rom_force_en ? rom_force_val : rom_fn(bus.read_address, bus.frame_sel);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: sprite box and row-major address from plain integer arithmetic.
    typedef struct packed {
        logic [8:0]  addr;
        logic        on;
        logic [11:0] color;
    } exp_t;

    function automatic exp_t model(input int dx, input int dy, input int mx, input int my,
                                   input bit fl);
        exp_t        e;
        int          col;
        int          row;
        bit          inb;
        bit          mirror;
        logic [11:0] rc;
        inb    = (dx >= mx) && (dx < mx + int'(SPR_W)) && (dy >= my) && (dy < my + int'(SPR_H));
        col    = dx - mx;
        row    = dy - my;
        mirror = fl;
`ifndef MARIO_MIRROR_EN
        mirror = 1'b0;
`endif
        if (mirror) col = int'(SPR_W) - 1 - col;
        e.addr  = inb ? 9'(row * int'(SPR_W) + col) : 9'd0;
        rc      = rom_fn(e.addr, 2'd0);
        e.on    = inb && (rc != KEY_COLOR);
        e.color = e.on ? rc : 12'h000;
        return e;
    endfunction

    typedef struct {
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [9:0]  mx;
        logic [9:0]  my;
        logic        fl;
        logic [11:0] rom;
        logic [8:0]  exp_addr;
        logic        exp_on;
        logic [11:0] exp_color;
    } vec_t;

    vec_t vecs[12];
    exp_t pipe_q[$];

    function automatic int exp_walk(input int n);
        if (n == 0) return 0;
        return ((n - 1) / int'(ANIM_DIV)) % 3 + 1;
    endfunction

    // All tasks below are entered and left at a falling clock edge.
    task automatic fclk_pulse();
        bus.frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic latch_frame();
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        @(negedge Clk);
        bus.DrawX = 10'd5;
        bus.DrawY = 10'd5;
    endtask

    initial begin
        exp_t e;
        int   prev;
        int   ex;
        logic [9:0] mx, my, dx, dy;
        logic fl;

        vecs[0]  = '{10'd103,  10'd52, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd45,  1'b1, 12'hF30};
        vecs[1]  = '{10'd103,  10'd52, 10'd100,  10'd50, 1'b0, 12'h808, 9'd45,  1'b0, 12'h000};
        vecs[2]  = '{10'd121,  10'd52, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};
        vecs[3]  = '{10'd120,  10'd52, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd62,  1'b1, 12'hF30};
        vecs[4]  = '{10'd103,  10'd52, 10'd100,  10'd50, 1'b1, 12'hF30, EXP_MIR, 1'b1, 12'hF30};
        vecs[5]  = '{10'd1023, 10'd52, 10'd1015, 10'd50, 1'b0, 12'hF30, 9'd50,  1'b1, 12'hF30};
        vecs[6]  = '{10'd0,    10'd52, 10'd1015, 10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};
        vecs[7]  = '{10'd4,    10'd52, 10'd1015, 10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};
        vecs[8]  = '{10'd100,  10'd70, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd420, 1'b1, 12'hF30};
        vecs[9]  = '{10'd100,  10'd71, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};
        vecs[10] = '{10'd99,   10'd52, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};
        vecs[11] = '{10'd100,  10'd49, 10'd100,  10'd50, 1'b0, 12'hF30, 9'd0,   1'b0, 12'h000};

        Reset           = 1'b1;
        bus.frame_clk   = 1'b0;
        bus.DrawX       = 10'd103;
        bus.DrawY       = 10'd52;
        bus.MarioX      = 10'd100;
        bus.MarioY      = 10'd50;
        bus.walking     = 1'b0;
        bus.facing_left = 1'b0;

        #1;
        check("reset read_address", 32'(bus.read_address), 32'd0);
        check("reset frame_sel", 32'(bus.frame_sel), 32'd0);
        check("reset pixel_on", 32'(bus.pixel_on), 32'd0);
        check("reset pixel_color", 32'(bus.pixel_color), 32'd0);
        repeat (2) @(negedge Clk);
        check("reset held pixel_on", 32'(bus.pixel_on), 32'd0);
        Reset = 1'b0;

        // Directed vectors: inputs held two cycles, address after one, pixel after two.
        for (int i = 0; i < 12; i++) begin
            bus.DrawX       = vecs[i].dx;
            bus.DrawY       = vecs[i].dy;
            bus.MarioX      = vecs[i].mx;
            bus.MarioY      = vecs[i].my;
            bus.facing_left = vecs[i].fl;
            rom_force_val   = vecs[i].rom;
            @(negedge Clk);
            check($sformatf("vec%0d read_address", i), 32'(bus.read_address),
                  32'(vecs[i].exp_addr));
            @(negedge Clk);
            check($sformatf("vec%0d pixel_on", i), 32'(bus.pixel_on), 32'(vecs[i].exp_on));
            check($sformatf("vec%0d pixel_color", i), 32'(bus.pixel_color),
                  32'(vecs[i].exp_color));
        end

        // Random stream, one new coordinate per cycle, ROM pattern driven by address.
        rom_force_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            mx = 10'($urandom_range(0, 1023));
            my = 10'($urandom_range(0, 1023));
            dx = 10'(int'(mx) + int'($urandom_range(0, SPR_W + 9)) - 5);
            dy = 10'(int'(my) + int'($urandom_range(0, SPR_H + 9)) - 5);
            fl = 1'($urandom_range(0, 1));
            bus.DrawX       = dx;
            bus.DrawY       = dy;
            bus.MarioX      = mx;
            bus.MarioY      = my;
            bus.facing_left = fl;
            pipe_q.push_back(model(int'(dx), int'(dy), int'(mx), int'(my), fl));
            @(negedge Clk);
            e = pipe_q[$];
            check($sformatf("rand%0d read_address", i), 32'(bus.read_address), 32'(e.addr));
            if (pipe_q.size() >= 2) begin
                e = pipe_q[pipe_q.size() - 2];
                check($sformatf("rand%0d pixel_on", i), 32'(bus.pixel_on), 32'(e.on));
                check($sformatf("rand%0d pixel_color", i), 32'(bus.pixel_color), 32'(e.color));
                void'(pipe_q.pop_front());
            end
        end

        // Animation: 13 frame_clk pulses while walking; frame_sel only follows at (0,0).
        bus.MarioX      = 10'd500;
        bus.MarioY      = 10'd400;
        bus.DrawX       = 10'd5;
        bus.DrawY       = 10'd5;
        bus.facing_left = 1'b0;
        bus.walking     = 1'b1;
        @(negedge Clk);
        latch_frame();
        check("anim n0 frame_sel", 32'(bus.frame_sel), 32'd0);
        prev = 0;
        for (int n = 1; n <= 13; n++) begin
            fclk_pulse();
            check($sformatf("anim n%0d frame_sel held", n), 32'(bus.frame_sel), 32'(prev));
            latch_frame();
            ex = exp_walk(n);
            check($sformatf("anim n%0d frame_sel", n), 32'(bus.frame_sel), 32'(ex));
            prev = ex;
        end

        // Three more pulses leave WALK1 one edge short of advancing; drop walking on that edge.
        repeat (3) fclk_pulse();
        bus.walking   = 1'b0;
        bus.frame_clk = 1'b1;
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        bus.walking   = 1'b1;
        @(negedge Clk);
        latch_frame();
        check("drop frame_sel", 32'(bus.frame_sel), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            fclk_pulse();
            if (n == 1 || n == 4 || n == 5) begin
                latch_frame();
                check($sformatf("restart n%0d frame_sel", n), 32'(bus.frame_sel),
                      32'(exp_walk(n)));
            end
        end

        // Reset in WALK2 with an opaque pixel on screen.
        rom_force_en  = 1'b1;
        rom_force_val = 12'hF30;
        bus.MarioX    = 10'd100;
        bus.MarioY    = 10'd50;
        bus.DrawX     = 10'd103;
        bus.DrawY     = 10'd52;
        repeat (2) @(negedge Clk);
        check("pre-reset pixel_on", 32'(bus.pixel_on), 32'd1);
        check("pre-reset frame_sel", 32'(bus.frame_sel), 32'd2);
        Reset = 1'b1;
        #1;
        check("async reset frame_sel", 32'(bus.frame_sel), 32'd0);
        check("async reset pixel_on", 32'(bus.pixel_on), 32'd0);
        check("async reset pixel_color", 32'(bus.pixel_color), 32'd0);
        check("async reset read_address", 32'(bus.read_address), 32'd0);
        repeat (2) @(negedge Clk);
        check("reset hold pixel_on", 32'(bus.pixel_on), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check("post-reset c1 pixel_on", 32'(bus.pixel_on), 32'd0);
        check("post-reset c1 read_address", 32'(bus.read_address), 32'd45);
        @(negedge Clk);
        check("post-reset c2 pixel_on", 32'(bus.pixel_on), 32'd1);
        check("post-reset c2 pixel_color", 32'(bus.pixel_color), 32'hF30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mario_sprite_fetch.md
MARIO_SPRITE_FETCH -- requirements
Module: mario_sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 21, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 21, meaning sprite height in pixels; SPR_W*SPR_H SHALL not exceed 512.
REQ-003 SHALL have parameter ANIM_DIV, default 4, meaning frame_clk rising edges per walk-frame advance; legal range 1..15.
REQ-004 SHALL have parameter KEY_COLOR, default 12'h808, meaning transparent palette colour.
REQ-005 Clk  input  1  system clock; all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_clk  input  1  vertical-sync-rate level signal, synchronous to Clk.
REQ-008 DrawX, DrawY  input  10 each  current VGA pixel coordinate.
REQ-009 MarioX, MarioY  input  10 each  sprite top-left coordinate.
REQ-010 walking  input  1  high while Mario moves horizontally.
REQ-011 facing_left  input  1  high when Mario faces left.
REQ-012 read_address  output  9  address to sprite ROM, row-major: row*SPR_W+col.
REQ-013 frame_sel  output  2  walk-frame ROM select: 0 stand, 1..3 walk frames.
REQ-014 rom_color  input  12  combinational ROM data for read_address/frame_sel.
REQ-015 pixel_on  output  1  high when pixel_color is an opaque sprite pixel.
REQ-016 pixel_color  output  12  sprite colour; 12'h000 when pixel_on low.

Function
REQ-017 In-box test SHALL be MarioX<=DrawX<MarioX+SPR_W and MarioY<=DrawY<MarioY+SPR_H, computed at 11-bit width so no wrap at 1023.
REQ-018 Stage 1: read_address, frame_sel and an in-box flag SHALL register one cycle after DrawX/DrawY are presented; read_address SHALL be 0 when out of box.
REQ-019 Stage 2: pixel_on SHALL register (in-box flag AND rom_color!=KEY_COLOR) and pixel_color SHALL register rom_color if pixel_on else 0; total latency DrawX/DrawY to pixel_on/pixel_color is 2 cycles.
REQ-020 frame_clk rising edge SHALL be detected with a registered previous value; a held-high level SHALL count once.
REQ-021 Animation FSM states: STAND(frame_sel 0), WALK1(1), WALK2(2), WALK3(3).
REQ-022 In STAND with walking high, next frame_clk edge SHALL go to WALK1 and clear the divider counter.
REQ-023 In WALKn, each frame_clk edge SHALL increment the divider; on reaching ANIM_DIV the divider SHALL clear and state advance WALK1->WALK2->WALK3->WALK1.
REQ-024 walking low SHALL force STAND and clear the divider on the next Clk edge from any state, taking priority over a simultaneous advance.
REQ-025 frame_sel output SHALL change only on Clk edges where DrawX==0 and DrawY==0 (latched from FSM state) so a frame never mixes two walk frames.

Reset
REQ-026 Reset high SHALL asynchronously set FSM to STAND, divider 0, edge register 0, read_address 0, frame_sel 0, in-box flag 0, pixel_on 0, pixel_color 0.
REQ-027 Reset asserted mid-frame SHALL hold all outputs at reset values; first valid pixel_on is two cycles after Reset deasserts.

Configuration
REQ-028 Macro MARIO_MIRROR_EN defined: when facing_left is high, column SHALL be SPR_W-1-(DrawX-MarioX), giving a horizontally mirrored sprite from the right-facing ROMs.
REQ-029 Macro MARIO_MIRROR_EN undefined: facing_left SHALL be ignored and column is always DrawX-MarioX.

Verification
REQ-030 Reset mid-walk: assert Reset in WALK2 -> frame_sel=0, pixel_on=0 immediately, without a Clk edge.
REQ-031 Address map: MarioX=100, MarioY=50, DrawX=103, DrawY=52, facing_left=0 -> read_address=45 one cycle later; DrawX=121 -> pixel_on=0 two cycles later.
REQ-032 Mirror (MARIO_MIRROR_EN): same position, facing_left=1, DrawX=103 -> read_address=59; without macro -> 45.
REQ-033 Transparency: in-box, rom_color=12'h808 -> pixel_on=0, pixel_color=0; rom_color=12'hF30 -> pixel_on=1, pixel_color=12'hF30.
REQ-034 Animation: walking=1, 13 frame_clk pulses, ANIM_DIV=4 -> states STAND,WALK1(after 1),WALK2(after 5),WALK3(after 9),WALK1(after 13); frame_sel updates only at DrawX=DrawY=0.
REQ-035 Edge: MarioX=1015 -> DrawX=1023 in box (col 8), DrawX=0..4 not in box; walking drop coincident with advance edge -> STAND.
